// File: rtl/uart_frame_sched.sv
// Host frame parser and SD command scheduler between the UART receiver and the SD/FIFO path.
// Frames are len_hi, len_lo, payload[len], 0x00; every outcome is reported on a status strobe.
module uart_frame_sched #(
  parameter int unsigned TIMEOUT_CYC = 208000,
  parameter int unsigned MAX_LEN     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  fifo_wdata,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        sd_req,
  output logic [1:0]  sd_cmd,
  input  logic        sd_ack,
  input  logic        sd_done,
  input  logic        sd_err,
  output logic [31:0] sd_sector,
  output logic        busy,
  output logic        status_valid,
  output logic [3:0]  status_code
);
  localparam int unsigned   CntW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] ToLimit = CntW'(TIMEOUT_CYC);
  localparam logic [15:0]   MaxLenW  = 16'(MAX_LEN);

  localparam logic [3:0] CodeFrameOk = 4'd0, CodeLenErr = 4'd1, CodeTrailerErr = 4'd2,
                         CodeBadOp = 4'd3, CodeBusy = 4'd4, CodeOverflow = 4'd5,
                         CodeTimeout = 4'd6, CodeSdOk = 4'd8, CodeSdFail = 4'd9;

  typedef enum logic [2:0] {PIdle, PLenLo, PFirst, PArg, PData, PTrailer, PDrain} pstate_e;
  typedef enum logic [1:0] {FtCmd, FtSector, FtData} ftype_e;
  typedef enum logic [1:0] {SIdle, SIssue, SWait} sstate_e;

  pstate_e         p_q, p_d;
  ftype_e          ftype_q, ftype_d;
  sstate_e         s_q, s_d;
  logic [15:0]     len_q, len_d, rem_q, rem_d;
  logic [7:0]      op_q, op_d;
  logic [31:0]     shadow_q, shadow_d, sector_q, sector_d;
  logic [1:0]      arg_cnt_q, arg_cnt_d, cmd_q, cmd_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic [7:0]      fifo_wdata_q, fifo_wdata_d;
  logic            stat_v_q, stat_v_d, pend_v_q, pend_v_d;
  logic [3:0]      stat_code_q, stat_code_d, pend_code_q, pend_code_d;

  logic        p_ev, sd_ev, launch, timed_out;
  logic [3:0]  p_code, sd_code;
  logic [1:0]  launch_cmd;
  logic [15:0] new_len;

  assign new_len   = {len_q[15:8], rx_data};
  assign timed_out = (p_q != PIdle) && !rx_valid && (to_cnt_q == ToLimit);

  // Parser next-state
  always_comb begin
    p_d          = p_q;
    ftype_d      = ftype_q;
    len_d        = len_q;
    rem_d        = rem_q;
    op_d         = op_q;
    shadow_d     = shadow_q;
    arg_cnt_d    = arg_cnt_q;
    ovf_d        = ovf_q;
    sector_d     = sector_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    p_ev         = 1'b0;
    p_code       = CodeFrameOk;
    launch       = 1'b0;
    launch_cmd   = 2'b00;

    if (p_q == PIdle || rx_valid) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToLimit) begin
      to_cnt_d = to_cnt_q + CntW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    unique case (op_q)
      8'h02:   launch_cmd = 2'b01;
      8'h03:   launch_cmd = 2'b10;
      8'h04:   launch_cmd = 2'b11;
      default: launch_cmd = 2'b00;
    endcase

    if (timed_out) begin
      p_d   = PIdle;
      ovf_d = 1'b0;
      if (p_q != PDrain) begin
        p_ev   = 1'b1;
        p_code = CodeTimeout;
      end
    end else if (rx_valid) begin
      case (p_q)
        PIdle: begin
          len_d[15:8] = rx_data;
          p_d         = PLenLo;
        end
        PLenLo: begin
          len_d[7:0] = rx_data;
          if (new_len == 16'd0 || new_len > MaxLenW) begin
            p_ev   = 1'b1;
            p_code = CodeLenErr;
            p_d    = PDrain;
          end else begin
            p_d = PFirst;
          end
        end
        PFirst: begin
          if (len_q == 16'd1) begin
            op_d    = rx_data;
            ftype_d = FtCmd;
            p_d     = PTrailer;
          end else if (len_q == 16'd5 && rx_data == 8'h05) begin
            ftype_d   = FtSector;
            arg_cnt_d = 2'd0;
            p_d       = PArg;
          end else begin
            // len >= 2 here, so at least one more data byte follows
            ftype_d      = FtData;
            fifo_wr_d    = !fifo_full;
            fifo_wdata_d = rx_data;
            ovf_d        = ovf_q | fifo_full;
            rem_d        = len_q - 16'd1;
            p_d          = PData;
          end
        end
        PArg: begin
          shadow_d  = {shadow_q[23:0], rx_data};
          arg_cnt_d = arg_cnt_q + 2'd1;
          if (arg_cnt_q == 2'd3) p_d = PTrailer;
        end
        PData: begin
          fifo_wr_d    = !fifo_full;
          fifo_wdata_d = rx_data;
          ovf_d        = ovf_q | fifo_full;
          rem_d        = rem_q - 16'd1;
          if (rem_q == 16'd1) p_d = PTrailer;
        end
        PTrailer: begin
          p_d   = PIdle;
          ovf_d = 1'b0;
          p_ev  = 1'b1;
          if (rx_data != 8'h00) begin
            p_code = CodeTrailerErr;
          end else begin
            case (ftype_q)
              FtCmd: begin
                if (launch_cmd == 2'b00) p_code = CodeBadOp;
                else if (s_q != SIdle)   p_code = CodeBusy;
                else                     launch = 1'b1;
              end
              FtSector: sector_d = shadow_q;
              default:  p_code = ovf_q ? CodeOverflow : CodeFrameOk;
            endcase
          end
        end
        default: p_d = p_q;  // PDrain swallows bytes until the link goes quiet
      endcase
    end
  end

  // SD scheduler next-state
  always_comb begin
    s_d     = s_q;
    cmd_d   = cmd_q;
    sd_ev   = 1'b0;
    sd_code = sd_err ? CodeSdFail : CodeSdOk;
    case (s_q)
      SIdle: begin
        if (launch) begin
          s_d   = SIssue;
          cmd_d = launch_cmd;
        end
      end
      SIssue: begin
        if (sd_ack) begin
          s_d   = sd_done ? SIdle : SWait;
          sd_ev = sd_done;
        end
      end
      SWait: begin
        if (sd_done) begin
          s_d   = SIdle;
          sd_ev = 1'b1;
        end
      end
      default: s_d = SIdle;
    endcase
  end

  // Parser codes win a collision; the SD code waits one cycle in the pending slot
  always_comb begin
    stat_v_d    = 1'b0;
    stat_code_d = stat_code_q;
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
    if (p_ev) begin
      stat_v_d    = 1'b1;
      stat_code_d = p_code;
      if (sd_ev && !pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_code_d = sd_code;
      end
    end else if (pend_v_q) begin
      stat_v_d    = 1'b1;
      stat_code_d = pend_code_q;
      pend_v_d    = sd_ev;
      pend_code_d = sd_code;
    end else if (sd_ev) begin
      stat_v_d    = 1'b1;
      stat_code_d = sd_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= PIdle;
      ftype_q      <= FtCmd;
      s_q          <= SIdle;
      len_q        <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      shadow_q     <= '0;
      sector_q     <= '0;
      arg_cnt_q    <= '0;
      cmd_q        <= '0;
      ovf_q        <= 1'b0;
      to_cnt_q     <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      stat_v_q     <= 1'b0;
      stat_code_q  <= '0;
      pend_v_q     <= 1'b0;
      pend_code_q  <= '0;
    end else begin
      p_q          <= p_d;
      ftype_q      <= ftype_d;
      s_q          <= s_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      shadow_q     <= shadow_d;
      sector_q     <= sector_d;
      arg_cnt_q    <= arg_cnt_d;
      cmd_q        <= cmd_d;
      ovf_q        <= ovf_d;
      to_cnt_q     <= to_cnt_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      stat_v_q     <= stat_v_d;
      stat_code_q  <= stat_code_d;
      pend_v_q     <= pend_v_d;
      pend_code_q  <= pend_code_d;
    end
  end

  assign fifo_wr      = fifo_wr_q;
  assign fifo_wdata   = fifo_wdata_q;
  assign sd_req       = (s_q == SIssue);
  assign sd_cmd       = cmd_q;
  assign sd_sector    = sector_q;
  assign busy         = (s_q != SIdle);
  assign status_valid = stat_v_q;
  assign status_code  = stat_code_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched: random frames checked against a whole-frame reference model.
module tb_uart_frame_sched;
  localparam int unsigned TO   = 300;
  localparam int unsigned MAXL = 1024;
  localparam logic [3:0] C_OK = 4'd0, C_LEN = 4'd1, C_TRL = 4'd2, C_BAD = 4'd3, C_BUSY = 4'd4,
                         C_OVF = 4'd5, C_TO = 4'd6, C_SDOK = 4'd8, C_SDFAIL = 4'd9;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, fifo_full = 1'b0;
  logic        sd_ack = 1'b0, sd_done = 1'b0, sd_err = 1'b0;
  logic [7:0]  fifo_wdata;
  logic        fifo_wr, sd_req, busy, status_valid;
  logic [1:0]  sd_cmd;
  logic [31:0] sd_sector;
  logic [3:0]  status_code;

  always #5 clk = ~clk;

  uart_frame_sched #(.TIMEOUT_CYC(TO), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_wdata(fifo_wdata), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
    .sd_req(sd_req), .sd_cmd(sd_cmd), .sd_ack(sd_ack), .sd_done(sd_done), .sd_err(sd_err),
    .sd_sector(sd_sector), .busy(busy), .status_valid(status_valid), .status_code(status_code)
  );

  int n_total = 0, n_pass = 0, n_fail = 0, cyc = 0;
  logic [3:0]  st_obs[$];
  int          st_cyc[$];
  logic [7:0]  fw_obs[$];
  logic [7:0]  frm[$];
  bit          frm_full[$];
  logic [7:0]  exp_wr[$];
  logic [3:0]  exp_code;
  bit          exp_launch;
  logic [1:0]  exp_cmd;
  logic [31:0] m_sector = '0;
  bit          m_idle = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (status_valid) begin
      st_obs.push_back(status_code);
      st_cyc.push_back(cyc);
    end
    if (fifo_wr) fw_obs.push_back(fifo_wdata);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit full_at(input int i);
    return (i < frm_full.size()) ? frm_full[i] : 1'b0;
  endfunction

  // Reference: judge a complete frame as a whole from its length, payload and trailer.
  task automatic model_frame();
    int len;
    bit ovf;
    len = int'({frm[0], frm[1]});
    exp_wr.delete();
    exp_launch = 1'b0;
    exp_cmd = 2'b00;
    ovf = 1'b0;
    if (len == 0 || len > int'(MAXL)) begin
      exp_code = C_LEN;
      return;
    end
    if (len == 1) begin
      if (frm[3] != 8'h00) exp_code = C_TRL;
      else if (frm[2] < 8'd2 || frm[2] > 8'd4) exp_code = C_BAD;
      else if (!m_idle) exp_code = C_BUSY;
      else begin
        exp_code = C_OK;
        exp_launch = 1'b1;
        exp_cmd = 2'(frm[2] - 8'd1);
      end
    end else if (len == 5 && frm[2] == 8'h05) begin
      if (frm[7] != 8'h00) exp_code = C_TRL;
      else begin
        exp_code = C_OK;
        m_sector = {frm[3], frm[4], frm[5], frm[6]};
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        if (full_at(2 + i)) ovf = 1'b1;
        else exp_wr.push_back(frm[2 + i]);
      end
      exp_code = (frm[2 + len] != 8'h00) ? C_TRL : (ovf ? C_OVF : C_OK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit full, input bit with_done, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    fifo_full = full;
    if (with_done) begin
      sd_done = 1'b1;
      sd_err = 1'b0;
    end
    tick(1);
    rx_valid = 1'b0;
    fifo_full = 1'b0;
    sd_done = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_frame(input bit done_on_last);
    for (int i = 0; i < frm.size(); i++)
      send_byte(frm[i], full_at(i), done_on_last && (i == frm.size() - 1),
                int'($urandom_range(4, 1)));
  endtask

  task automatic expect_status(input string tag, input logic [3:0] code);
    check({tag, "_cnt"}, st_obs.size(), 1);
    if (st_obs.size() > 0) check(tag, {28'd0, st_obs[0]}, {28'd0, code});
    st_obs.delete();
    st_cyc.delete();
  endtask

  task automatic expect_fifo(input string tag);
    check({tag, "_nwr"}, fw_obs.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < fw_obs.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {24'd0, fw_obs[i]}, {24'd0, exp_wr[i]});
    fw_obs.delete();
  endtask

  task automatic run_frame(input string tag);
    model_frame();
    send_frame(1'b0);
    tick(3);
    expect_status(tag, exp_code);
    expect_fifo(tag);
    if (exp_launch) m_idle = 1'b0;
  endtask

  task automatic sd_pulse(input bit ack, input bit done, input bit err);
    sd_ack = ack;
    sd_done = done;
    sd_err = err;
    tick(1);
    sd_ack = 1'b0;
    sd_done = 1'b0;
    sd_err = 1'b0;
  endtask

  task automatic complete(input string tag, input bit err);
    check({tag, "_busy_done"}, busy, 1);
    sd_pulse(1'b0, 1'b1, err);
    check({tag, "_busy_end"}, busy, 0);
    tick(2);
    expect_status({tag, "_sd"}, err ? C_SDFAIL : C_SDOK);
    m_idle = 1'b1;
  endtask

  initial begin
    int k;
    bit e;
    tick(3);
    check("rst_req", sd_req, 0);
    check("rst_cmd", sd_cmd, 0);
    check("rst_sector", sd_sector, 0);
    check("rst_busy", busy, 0);
    check("rst_sv", status_valid, 0);
    check("rst_code", status_code, 0);
    check("rst_fwr", fifo_wr, 0);
    check("rst_fwd", fifo_wdata, 0);
    rst = 1'b0;
    tick(2);

    frm = '{8'h00, 8'h01, 8'h02, 8'h00}; frm_full.delete();
    run_frame("init");
    check("init_req", sd_req, 1);
    check("init_cmd", sd_cmd, exp_cmd);
    check("init_busy", busy, 1);
    tick(int'($urandom_range(6, 2)));
    check("init_req_hold", sd_req, 1);
    check("init_cmd_hold", sd_cmd, 2'b01);
    sd_pulse(1'b1, 1'b0, 1'b0);
    check("init_req_drop", sd_req, 0);
    complete("init", 1'b0);

    sd_pulse(1'b0, 1'b1, 1'b0);
    tick(3);
    check("stray_done", st_obs.size(), 0);

    frm = '{8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00};
    run_frame("sec1");
    check("sec1_val", sd_sector, 32'h0000_1234);
    frm = '{8'h00, 8'h05, 8'h05, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h00};
    run_frame("sec2");
    check("sec2_val", sd_sector, m_sector);

    frm = '{8'h00, 8'h01, 8'h03, 8'h00};
    run_frame("read");
    check("read_cmd", sd_cmd, exp_cmd);
    e = 1'($urandom_range(1, 0));
    sd_pulse(1'b1, 1'b1, e);
    check("ackdone_busy", busy, 0);
    tick(2);
    expect_status("ackdone_sd", e ? C_SDFAIL : C_SDOK);
    m_idle = 1'b1;

    frm = '{8'h00, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00}; frm_full.delete();
    run_frame("data4");
    frm_full = '{0, 0, 0, 0, 1, 0, 0};
    run_frame("ovf4");

    for (int it = 0; it < 6; it++) begin
      int len;
      len = int'($urandom_range(12, 2));
      frm.delete(); frm_full.delete();
      frm.push_back(8'h00); frm.push_back(8'(len));
      frm_full.push_back(1'b0); frm_full.push_back(1'b0);
      for (int i = 0; i < len; i++) begin
        frm.push_back(8'($urandom));
        frm_full.push_back($urandom_range(3, 0) == 0);
      end
      frm.push_back(8'h00); frm_full.push_back(1'b0);
      run_frame($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_sec", it), sd_sector, m_sector);
    end

    frm.delete(); frm_full.delete();
    frm.push_back(8'h04); frm.push_back(8'h00);
    for (int i = 0; i < int'(MAXL); i++) frm.push_back(8'($urandom));
    frm.push_back(8'h00);
    run_frame("maxlen");

    frm = '{8'h04, 8'h01, 8'h00, 8'h01, 8'h02, 8'h00};
    run_frame("len1025");
    tick(TO + 20);
    check("drain_silent", st_obs.size(), 0);
    frm = '{8'h00, 8'h00, 8'h00};
    run_frame("len0");
    tick(TO + 20);
    check("drain0_silent", st_obs.size(), 0);

    frm = '{8'h00, 8'h01, 8'h04, 8'h00};
    run_frame("write");
    check("write_cmd", sd_cmd, 2'b11);
    sd_pulse(1'b1, 1'b0, 1'b0);
    frm = '{8'h00, 8'h01, 8'h03, 8'h00};
    run_frame("busy");
    check("busy_noreq", sd_req, 0);
    check("busy_cmd_kept", sd_cmd, 2'b11);
    complete("busy", 1'b1);

    frm = '{8'h00, 8'h01, 8'($urandom_range(255, 5)), 8'h00};
    run_frame("badop");
    check("badop_noreq", sd_req, 0);
    frm = '{8'h00, 8'h01, 8'h02, 8'($urandom_range(255, 1))};
    run_frame("trl");
    check("trl_noreq", sd_req, 0);

    send_byte(8'h00, 1'b0, 1'b0, 2);
    send_byte(8'h03, 1'b0, 1'b0, 2);
    send_byte(8'h11, 1'b0, 1'b0, 0);
    k = 0;
    for (int i = 1; i <= int'(TO) + 10; i++) begin
      tick(1);
      if (status_valid) begin
        k = i;
        break;
      end
    end
    check("timeout_window", (k >= int'(TO) && k <= int'(TO) + 2), 1);
    tick(2);
    expect_status("timeout", C_TO);
    exp_wr = '{8'h11};
    expect_fifo("timeout");

    frm = '{8'h00, 8'h01, 8'h02, 8'h00}; frm_full.delete();
    run_frame("coll_cmd");
    sd_pulse(1'b1, 1'b0, 1'b0);
    frm = '{8'h00, 8'h05, 8'h05, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h00};
    model_frame();
    send_frame(1'b1);
    tick(3);
    check("coll_cnt", st_obs.size(), 2);
    if (st_obs.size() == 2) begin
      check("coll_first", {28'd0, st_obs[0]}, {28'd0, C_OK});
      check("coll_second", {28'd0, st_obs[1]}, {28'd0, C_SDOK});
      check("coll_adjacent", st_cyc[1] - st_cyc[0], 1);
    end
    st_obs.delete(); st_cyc.delete();
    m_idle = 1'b1;
    check("coll_sector", sd_sector, m_sector);

    frm = '{8'h00, 8'h01, 8'h03, 8'h00};
    run_frame("rstcmd");
    check("rstcmd_req", sd_req, 1);
    send_byte(8'h00, 1'b0, 1'b0, 1);
    send_byte(8'h03, 1'b0, 1'b0, 1);
    rst = 1'b1;
    tick(1);
    check("rst2_req", sd_req, 0);
    check("rst2_busy", busy, 0);
    check("rst2_sector", sd_sector, 0);
    rst = 1'b0;
    m_sector = '0;
    m_idle = 1'b1;
    tick(2);
    sd_pulse(1'b0, 1'b1, 1'b0);
    tick(3);
    check("rst2_silent", st_obs.size(), 0);
    frm = '{8'h00, 8'h01, 8'h02, 8'h00};
    run_frame("post");
    check("post_cmd", sd_cmd, 2'b01);
    sd_pulse(1'b1, 1'b0, 1'b0);
    complete("post", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_frame_sched.md
Name: uart_frame_sched

Overview:
- Sits between the UART byte receiver and the SD-card SPI controller / write-data FIFO in `top`.
- Parses host frames arriving on the 9600-baud link.
  - Frame format: len_hi, len_lo, payload[len], trailer 0x00.
- Dispatches frames by length:
  - 1-byte command payloads are scheduled onto the SD controller with a req/ack/done handshake.
  - Sector-set payloads load the SD sector register.
  - Bulk payloads are streamed into the write FIFO.
- Reports every outcome on a one-cycle status strobe.

Parameters:
- TIMEOUT_CYC, 208000, inter-byte idle limit in clk cycles (~4 byte times at 50 MHz); counter width = clog2(TIMEOUT_CYC+1).
- MAX_LEN, 1024, largest legal payload length; larger lengths are a length error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- fifo_wdata  out  8  byte to write FIFO
- fifo_wr  out  1  write strobe
- fifo_full  in  1  FIFO full
- sd_req  out  1  SD operation request
- sd_cmd  out  2  01 init, 10 read, 11 write
- sd_ack  in  1  one-cycle: controller accepted request
- sd_done  in  1  one-cycle: operation finished
- sd_err  in  1  qualifies sd_done, 1 = failure
- sd_sector  out  32  current sector address
- busy  out  1  SD operation outstanding (ISSUE or WAIT)
- status_valid  out  1  one-cycle status strobe
- status_code  out  4  see below

Behaviour:

Reset: all outputs 0, parser in IDLE, scheduler in S_IDLE, overflow flag clear, pending status clear.

Status codes:
- 0 FRAME_OK
- 1 LEN_ERR
- 2 TRAILER_ERR
- 3 BAD_OP
- 4 BUSY
- 5 OVERFLOW
- 6 TIMEOUT
- 8 SD_OK
- 9 SD_FAIL

Parser states: IDLE -> LEN_LO -> FIRST -> (CMD_WAIT_TRL | ARG | DATA) -> TRAILER -> IDLE; plus DRAIN.
- IDLE: rx byte -> len[15:8]. LEN_LO: rx byte -> len[7:0].
  - len==0 or len>MAX_LEN -> LEN_ERR strobe, enter DRAIN.
- FIRST (first payload byte):
  - len==1: byte is the opcode; latched, go TRAILER.
  - len==5 and byte==0x05: sector-set; go ARG for 4 big-endian bytes into a shadow register.
  - Otherwise: bulk data; byte goes to the FIFO, go DATA with remaining = len-1 (TRAILER if 0).
- DATA:
  - Each byte drives fifo_wdata with fifo_wr=1 exactly one cycle after its rx_valid.
  - If fifo_full is high in the rx_valid cycle, the byte is dropped (no fifo_wr) and the sticky overflow flag is set.
- TRAILER: byte must be 0x00, else TRAILER_ERR and no frame action. On 0x00:
  - Opcode frame:
    - 0x02/0x03/0x04 map to sd_cmd 01/10/11.
    - Other opcodes -> BAD_OP.
    - Scheduler not in S_IDLE -> BUSY, command discarded.
    - Otherwise command latched and FRAME_OK.
  - Sector frame: shadow -> sd_sector, FRAME_OK.
  - Data frame: OVERFLOW if flag set, else FRAME_OK. Flag clears at frame end.
- Timeout: counter clears on every rx_valid and in IDLE.
  - Reaching TIMEOUT_CYC in any parse state other than IDLE or DRAIN -> TIMEOUT strobe, IDLE.
  - DRAIN discards bytes and returns to IDLE silently on timeout.
  - FIFO bytes and sector shadow already written are not rolled back; sd_sector is unchanged.

Scheduler states: S_IDLE -> S_ISSUE -> S_WAIT -> S_IDLE.
- S_ISSUE: sd_req=1 with sd_cmd held stable until the sd_ack cycle; sd_req drops the cycle after ack.
- S_WAIT: on sd_done, SD_OK or SD_FAIL per sd_err.
- sd_done outside S_WAIT is ignored.
- sd_ack and sd_done in the same cycle: treated as ack then immediate done, giving SD_OK/FAIL and a return to S_IDLE.

Status arbitration:
- Parser status and SD status in the same cycle: the parser code is emitted first, and the SD code is held in a one-entry pending register and emitted the next cycle.
- Codes are never lost; at most one strobe per cycle.

Reset mid-operation: sd_req drops immediately, sd_sector returns to 0, partial frame is discarded.

Test Plan:
- Bytes 00 01 02 00 -> FRAME_OK; sd_req with sd_cmd=01 until ack; sd_done(err=0) -> SD_OK; busy high from ISSUE until the done cycle.
- 00 05 05 00 00 12 34 00 -> FRAME_OK, sd_sector=0x00001234; then 00 01 03 00 -> sd_cmd=10.
- 00 04 A1 B2 C3 D4 00 -> four fifo_wr with A1,B2,C3,D4 in order, FRAME_OK. Repeat with fifo_full held during C3 -> three writes (A1,B2,D4), OVERFLOW.
- 00 01 04 00 issued, then 00 01 03 00 before sd_done -> second frame BUSY, no second sd_req; sd_done(err=1) -> SD_FAIL.
- Error frames:
  - 00 01 07 00 -> BAD_OP.
  - 00 01 02 55 -> TRAILER_ERR.
  - 04 01 .. -> LEN_ERR, DRAIN until idle.
  - 00 03 11 then silence -> TIMEOUT after TIMEOUT_CYC cycles.
- Trailer strobe in the same cycle as sd_done -> FRAME_OK then SD_OK on consecutive cycles. rst asserted during S_ISSUE -> sd_req=0 the next cycle and all state cleared.
